div: RTL and testbench

//   Sequential 32-bit signed integer divider for the multiply/divide unit.
//   A one-cycle start on MDControl latches the operands.
//   The quotient dividendo / divisor is computed by iterative restoring division,
//   one quotient bit per clock.
//   The quotient is published on resultado and held there until the next completed operation or reset.

---
 rtl/md_pkg.sv | 35 +++
 rtl/div_step.sv | 31 +++
 rtl/div.sv | 128 ++++++++++++
 tb/tb_div.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: datapath width, divider
// FSM states, the divide-by-zero result and a magnitude helper.
package md_pkg;

    localparam int WIDTH = 32;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] DIV0_RESULT = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] W_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO      = {WIDTH{1'b0}};

    // Two's complement magnitude; 0x8000_0000 yields unsigned 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = ~v + W_ONE;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's complement negation.
    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
        return ~v + W_ONE;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, then subtract the divisor if it fits.
module div_step
    import md_pkg::*;
(
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dvd,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_dvd,
    output logic             o_qbit
);

    // The compare is done one bit wider so no remainder bit is silently lost;
    // the remainder is always below the divisor, so its top bit is zero here.
    logic [WIDTH:0] w_rem_sh;

    // Shift, compare and conditionally subtract.
    always_comb begin
        w_rem_sh = {i_rem, i_dvd[WIDTH-1]};
        o_dvd    = {i_dvd[WIDTH-2:0], 1'b0};
        if (w_rem_sh >= {1'b0, i_dvs}) begin
            o_rem  = w_rem_sh[WIDTH-1:0] - i_dvs;
            o_qbit = 1'b1;
        end else begin
            o_rem  = w_rem_sh[WIDTH-1:0];
            o_qbit = 1'b0;
        end
    end

endmodule

// File: rtl/div.sv
// Sequential signed divider: works on operand magnitudes, one quotient bit
// per clock, then applies the quotient sign and registers the result.
module div
    import md_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             MDControl,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] dividendo,
    output logic [WIDTH-1:0] resultado
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic             r_sign;
    logic [CW-1:0]    r_count;
    logic             w_load;
    logic             w_run;
    logic             w_done;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_dvd_nxt;
    logic             w_qbit;

    div_step u_step (
        .i_rem  (r_rem),
        .i_dvd  (r_dvd),
        .i_dvs  (r_dvs),
        .o_rem  (w_rem_nxt),
        .o_dvd  (w_dvd_nxt),
        .o_qbit (w_qbit)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; start requests are only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (MDControl) begin
                    w_next_state = LOAD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOAD: w_next_state = RUN;
            RUN: begin
                if (r_count == CW'(1)) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM output decode: datapath enables per state.
    always_comb begin
        w_load = 1'b0;
        w_run  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            LOAD:    w_load = 1'b1;
            RUN:     w_run  = 1'b1;
            DONE:    w_done = 1'b1;
            default: begin
                w_load = 1'b0;
                w_run  = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Iteration datapath: latch magnitudes and sign, then one step per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dvd   <= W_ZERO;
            r_dvs   <= W_ZERO;
            r_rem   <= W_ZERO;
            r_quo   <= W_ZERO;
            r_sign  <= 1'b0;
            r_count <= CW'(0);
        end else if (w_load) begin
            r_dvd   <= abs_val(dividendo);
            r_dvs   <= abs_val(divisor);
            r_sign  <= dividendo[WIDTH-1] ^ divisor[WIDTH-1];
            r_rem   <= W_ZERO;
            r_quo   <= W_ZERO;
            r_count <= CW'(WIDTH);
        end else if (w_run) begin
            r_rem   <= w_rem_nxt;
            r_dvd   <= w_dvd_nxt;
            r_quo   <= {r_quo[WIDTH-2:0], w_qbit};
            r_count <= r_count - CW'(1);
        end
    end

    // Result register: sign fix-up, with a fixed all-ones answer for /0
    // regardless of the dividend sign.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resultado <= W_ZERO;
        end else if (w_done) begin
            if (r_dvs == W_ZERO) begin
                resultado <= DIV0_RESULT;
            end else if (r_sign) begin
                resultado <= neg_val(r_quo);
            end else begin
                resultado <= r_quo;
            end
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: a cycle-level transaction model (start accepted
// when idle, result visible 34 edges later, next start possible one edge after)
// is compared every cycle, plus hand-computed literal checks per operation.
module tb_div;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        MDControl = 1'b0;
    logic [31:0] divisor   = 32'h0;
    logic [31:0] dividendo = 32'h0;
    wire  [31:0] resultado;

    int n_vec = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    div dut (
        .clk       (clk),
        .reset     (reset),
        .MDControl (MDControl),
        .divisor   (divisor),
        .dividendo (dividendo),
        .resultado (resultado)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: signed truncating division in 64 bits.
    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        if (b == 32'h0) return 32'hFFFF_FFFF;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        q  = sa / sb;
        return q[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model.
    logic [31:0] exp_r;
    logic [31:0] pend_r;
    int          left_r;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_r  <= 32'h0;
            pend_r <= 32'h0;
            left_r <= 0;
        end else if (left_r == 0 && MDControl) begin
            pend_r <= model_div(dividendo, divisor);
            left_r <= 34;
        end else if (left_r > 0) begin
            left_r <= left_r - 1;
            if (left_r == 1) exp_r <= pend_r;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) check("model", resultado, exp_r);
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prev, input logic [31:0] lit);
        @(negedge clk);
        dividendo = a;
        divisor   = b;
        MDControl = 1'b1;
        @(negedge clk);
        MDControl = 1'b0;
        repeat (33) @(negedge clk);
        check("hold_before_done", resultado, prev);
        @(negedge clk);
        check("result", resultado, lit);
    endtask

    logic [31:0] op_a [7] = '{32'd100, 32'd2, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'd123, 32'h8000_0000};
    logic [31:0] op_b [7] = '{32'd5, 32'd10, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] op_q [7] = '{32'd20, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};

    logic [31:0] bb_a [3] = '{32'd1000, 32'h8000_0000, 32'd7};
    logic [31:0] bb_b [3] = '{32'hFFFF_FFF6, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] bb_q [3] = '{32'hFFFF_FF9C, 32'h8000_0000, 32'hFFFF_FFFD};

    initial begin
        logic [31:0] prev;

        // Async reset: output clears before any clock edge.
        #1 reset = 1'b1;
        #1 check("reset_async", resultado, 32'h0);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed operations, including sign cases and boundaries.
        prev = 32'h0;
        for (int i = 0; i < 7; i++) begin
            run_op(op_a[i], op_b[i], prev, op_q[i]);
            prev = op_q[i];
        end

        // Reset in the middle of RUN discards the division.
        @(negedge clk);
        dividendo = 32'd100;
        divisor   = 32'd5;
        MDControl = 1'b1;
        @(negedge clk);
        MDControl = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("mid_run_reset", resultado, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("no_late_result", resultado, 32'h0);
        run_op(32'd100, 32'd5, 32'h0, 32'd20);
        run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd20, 32'd3);

        // Start pulses and operand changes during RUN are ignored.
        @(negedge clk);
        dividendo = 32'd100;
        divisor   = 32'd5;
        MDControl = 1'b1;
        @(negedge clk);
        MDControl = 1'b0;
        repeat (5) @(negedge clk);
        MDControl = 1'b1;
        dividendo = 32'd999;
        divisor   = 32'd3;
        @(negedge clk);
        MDControl = 1'b0;
        dividendo = 32'd50;
        divisor   = 32'd0;
        repeat (27) @(negedge clk);
        check("ignore_hold", resultado, 32'd3);
        @(negedge clk);
        check("ignore_result", resultado, 32'd20);

        // MDControl held high: results every 35 cycles.
        @(negedge clk);
        dividendo = bb_a[0];
        divisor   = bb_b[0];
        MDControl = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            repeat ((k == 0) ? 34 : 35) @(negedge clk);
            check("b2b_result", resultado, bb_q[k]);
            if (k < 2) begin
                dividendo = bb_a[k+1];
                divisor   = bb_b[k+1];
            end else begin
                MDControl = 1'b0;
            end
        end
        repeat (40) @(negedge clk);
        check("final_hold", resultado, 32'hFFFF_FFFD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
